alu_ctrl_stage: RTL and testbench
=================================

Name: alu_ctrl_stage

Overview:
Decode and pipeline stage that produces the 4-bit ALU control code and operand-steering flags for the EX-stage ALU. Decodes the ID-stage instruction word (opcode/funct) into the ALU op encoding, then registers the result into the ID/EX boundary with stall and flush handling. Also flags unsupported instructions and keeps a saturating count of them for debug.

Parameters:
CNT_WIDTH, 8, width of the saturating illegal-instruction counter

Ports:
CLK  input  1  clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
InstrID  input  32  instruction word from ID stage
ValidID  input  1  InstrID holds a real instruction
Stall  input  1  hold all EX-side registers
Flush  input  1  replace the next EX contents with a bubble
ValidEX  output  1  EX-stage instruction valid
ALUCtrlEX  output  4  ALU operation code
ALUSrcImmEX  output  1  BusB takes the extended immediate, not rt
SignExtEX  output  1  1 = sign-extend imm16, 0 = zero-extend
ShamtSelEX  output  1  BusB takes the zero-extended shamt field
ShiftSwapEX  output  1  BusA takes rt, BusB takes rs (shift operand order)
ShamtEX  output  5  InstrID[10:6], registered
IllegalEX  output  1  unsupported opcode/funct decoded
IllegalCount  output  CNT_WIDTH  saturating count of accepted illegal instructions

Behaviour:
- ALU op encoding (fixed): AND 0000, OR 0001, ADD 0010, SLL 0011, SRL 0100, SUB 0110, SLT 0111, ADDU 1000, SUBU 1001, XOR 1010, SLTU 1011, NOR 1100, SRA 1101, LUI 1110.
- Shift semantics at the ALU: result = BusA shifted by BusB. Therefore every shift sets ShiftSwap=1 (BusA=rt).
- R-type (opcode 000000), by funct:
  - 000000 SLL, 000010 SRL, 000011 SRA: ShamtSel=1.
  - 000100 SLL, 000110 SRL, 000111 SRA (variable shifts): ShamtSel=0, BusB=rs.
  - 100000 ADD, 100001 ADDU, 100010 SUB, 100011 SUBU, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT, 101011 SLTU.
  - All R-type ops: ALUSrcImm=0, SignExt=0. Any other funct is illegal.
- I-type, by opcode (all ALUSrcImm=1 except beq/bne; ShamtSel=0; ShiftSwap=0):
  - 001000 ADD, 001001 ADDU, 001010 SLT, 001011 SLTU: SignExt=1.
  - 001100 AND, 001101 OR, 001110 XOR: SignExt=0.
  - 001111 LUI: SignExt=0.
  - 100011 lw and 101011 sw: ADD, SignExt=1.
  - 000100 beq and 000101 bne: SUB, ALUSrcImm=0, SignExt=1.
- Illegal opcode or funct: ALUCtrl=ADD, all flags 0, Illegal=1.
- Decode is combinational; the registered outputs appear 1 cycle after the edge that accepts InstrID. Latency is exactly 1 cycle.
- Update priority on each rising edge: Reset > Flush > Stall > load.
  - Reset: ValidEX=0, ALUCtrlEX=0000, all flags 0, ShamtEX=0, IllegalCount=0.
  - Flush (regardless of Stall): bubble loaded. ValidEX=0, ALUCtrlEX=0000, flags/Shamt 0, IllegalEX=0. Counter unchanged.
  - Stall without Flush: every EX register and the counter hold their values.
  - Load: ValidEX<=ValidID. Decoded fields are loaded. IllegalEX<=Illegal&ValidID.
- When ValidID=0 on a load, ValidEX=0 and IllegalEX=0. Decoded fields are still loaded, and downstream must not use them.
- IllegalCount increments by 1 only on a load cycle with ValidID=1 and Illegal=1. It saturates at 2^CNT_WIDTH-1 with no wrap, and clears only on Reset.
- 0x00000000 (nop) decodes as legal SLL with shamt 0, ShiftSwap=1, ShamtSel=1.
- Reset asserted mid-stall or mid-flush still clears everything on that edge.

Test Plan:
- Reset: hold Reset 2 cycles with ValidID=1 and InstrID=0x00221820 -> ValidEX=0, ALUCtrlEX=0000, IllegalCount=0.
- Loads, 1-cycle latency:
  - add 0x00221820 -> ALUCtrlEX=0010, ALUSrcImmEX=0, one cycle later.
  - sll 0x00031100 -> 0011, ShamtSelEX=1, ShiftSwapEX=1, ShamtEX=4.
  - srav 0x00431007 -> 1101, ShamtSelEX=0, ShiftSwapEX=1.
- Immediates:
  - lui 0x3C011234 -> 1110, ALUSrcImmEX=1, SignExtEX=0.
  - andi 0x3021FFFF -> 0000, SignExtEX=0.
  - slti 0x2821FFFF -> 0111, SignExtEX=1.
  - beq 0x10220003 -> 0110, ALUSrcImmEX=0.
- Stall/flush:
  - Load addu, then Stall=1 for 3 cycles while InstrID changes -> EX holds 1000.
  - Stall=1 with Flush=1 -> bubble: ValidEX=0, ALUCtrlEX=0000.
- Illegal handling:
  - 0x7C000000 with ValidID=1 -> IllegalEX=1, ALUCtrlEX=0010, IllegalCount=1.
  - Same word with ValidID=0 -> count unchanged.
  - Same word while stalled -> count unchanged.
  - CNT_WIDTH=2 with 5 illegal loads -> IllegalCount=3, holding at saturation.

Source files
------------

// File: rtl/alu_ctrl_stage.sv
// ID-stage ALU control decoder with a registered ID/EX boundary.
// Produces the ALU op code and operand-steering flags, plus a saturating count of unsupported instructions.
module alu_ctrl_stage #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic [31:0]          InstrID,
    input  logic                 ValidID,
    input  logic                 Stall,
    input  logic                 Flush,
    output logic                 ValidEX,
    output logic [3:0]           ALUCtrlEX,
    output logic                 ALUSrcImmEX,
    output logic                 SignExtEX,
    output logic                 ShamtSelEX,
    output logic                 ShiftSwapEX,
    output logic [4:0]           ShamtEX,
    output logic                 IllegalEX,
    output logic [CNT_WIDTH-1:0] IllegalCount
);

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SLL  = 4'b0011,
        OP_SRL  = 4'b0100,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_ADDU = 4'b1000,
        OP_SUBU = 4'b1001,
        OP_XOR  = 4'b1010,
        OP_SLTU = 4'b1011,
        OP_NOR  = 4'b1100,
        OP_SRA  = 4'b1101,
        OP_LUI  = 4'b1110
    } aluOp_e;

    logic [5:0] opcode;
    logic [5:0] funct;
    aluOp_e     aluCtrl;
    logic       aluSrcImm;
    logic       signExt;
    logic       shamtSel;
    logic       shiftSwap;
    logic       illegal;
    logic       unusedInstrBits;

    assign opcode          = InstrID[31:26];
    assign funct           = InstrID[5:0];
    assign unusedInstrBits = ^InstrID[25:11];

    // Shifts route rt onto BusA so the ALU always computes BusA shifted by BusB.
    always_comb begin
        aluCtrl   = OP_ADD;
        aluSrcImm = 1'b0;
        signExt   = 1'b0;
        shamtSel  = 1'b0;
        shiftSwap = 1'b0;
        illegal   = 1'b0;
        unique case (opcode)
            6'b000000: begin
                unique case (funct)
                    6'b000000: begin aluCtrl = OP_SLL; shamtSel = 1'b1; shiftSwap = 1'b1; end
                    6'b000010: begin aluCtrl = OP_SRL; shamtSel = 1'b1; shiftSwap = 1'b1; end
                    6'b000011: begin aluCtrl = OP_SRA; shamtSel = 1'b1; shiftSwap = 1'b1; end
                    6'b000100: begin aluCtrl = OP_SLL; shiftSwap = 1'b1; end
                    6'b000110: begin aluCtrl = OP_SRL; shiftSwap = 1'b1; end
                    6'b000111: begin aluCtrl = OP_SRA; shiftSwap = 1'b1; end
                    6'b100000: aluCtrl = OP_ADD;
                    6'b100001: aluCtrl = OP_ADDU;
                    6'b100010: aluCtrl = OP_SUB;
                    6'b100011: aluCtrl = OP_SUBU;
                    6'b100100: aluCtrl = OP_AND;
                    6'b100101: aluCtrl = OP_OR;
                    6'b100110: aluCtrl = OP_XOR;
                    6'b100111: aluCtrl = OP_NOR;
                    6'b101010: aluCtrl = OP_SLT;
                    6'b101011: aluCtrl = OP_SLTU;
                    default:   illegal = 1'b1;
                endcase
            end
            6'b001000: begin aluCtrl = OP_ADD;  aluSrcImm = 1'b1; signExt = 1'b1; end
            6'b001001: begin aluCtrl = OP_ADDU; aluSrcImm = 1'b1; signExt = 1'b1; end
            6'b001010: begin aluCtrl = OP_SLT;  aluSrcImm = 1'b1; signExt = 1'b1; end
            6'b001011: begin aluCtrl = OP_SLTU; aluSrcImm = 1'b1; signExt = 1'b1; end
            6'b001100: begin aluCtrl = OP_AND;  aluSrcImm = 1'b1; end
            6'b001101: begin aluCtrl = OP_OR;   aluSrcImm = 1'b1; end
            6'b001110: begin aluCtrl = OP_XOR;  aluSrcImm = 1'b1; end
            6'b001111: begin aluCtrl = OP_LUI;  aluSrcImm = 1'b1; end
            6'b100011,
            6'b101011: begin aluCtrl = OP_ADD;  aluSrcImm = 1'b1; signExt = 1'b1; end
            6'b000100,
            6'b000101: begin aluCtrl = OP_SUB;  signExt = 1'b1; end
            default:   illegal = 1'b1;
        endcase
    end

    // Flush beats Stall so a squashed slot never lingers in EX while the pipe is held.
    always_ff @(posedge CLK) begin
        if (Reset || Flush) begin
            ValidEX     <= 1'b0;
            ALUCtrlEX   <= OP_AND;
            ALUSrcImmEX <= 1'b0;
            SignExtEX   <= 1'b0;
            ShamtSelEX  <= 1'b0;
            ShiftSwapEX <= 1'b0;
            ShamtEX     <= 5'd0;
            IllegalEX   <= 1'b0;
        end else if (!Stall) begin
            ValidEX     <= ValidID;
            ALUCtrlEX   <= aluCtrl;
            ALUSrcImmEX <= aluSrcImm;
            SignExtEX   <= signExt;
            ShamtSelEX  <= shamtSel;
            ShiftSwapEX <= shiftSwap;
            ShamtEX     <= InstrID[10:6];
            IllegalEX   <= illegal & ValidID;
        end
    end

    // Debug counter sticks at all-ones rather than wrapping.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            IllegalCount <= '0;
        end else if (!Flush && !Stall && ValidID && illegal &&
                     (IllegalCount != {CNT_WIDTH{1'b1}})) begin
            IllegalCount <= IllegalCount + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Directed testbench for alu_ctrl_stage: decode vectors, stall/flush priority, illegal counting and saturation.
// A second instance with CNT_WIDTH=2 shares the stimulus to exercise counter saturation.
module tb_alu_ctrl_stage;

    logic        CLK;
    logic        Reset;
    logic [31:0] InstrID;
    logic        ValidID;
    logic        Stall;
    logic        Flush;

    logic        ValidEX;
    logic [3:0]  ALUCtrlEX;
    logic        ALUSrcImmEX;
    logic        SignExtEX;
    logic        ShamtSelEX;
    logic        ShiftSwapEX;
    logic [4:0]  ShamtEX;
    logic        IllegalEX;
    logic [7:0]  IllegalCount;

    logic        nValidEX;
    logic [3:0]  nALUCtrlEX;
    logic        nALUSrcImmEX;
    logic        nSignExtEX;
    logic        nShamtSelEX;
    logic        nShiftSwapEX;
    logic [4:0]  nShamtEX;
    logic        nIllegalEX;
    logic [1:0]  nIllegalCount;

    logic [9:0]  exBundle;
    logic [9:0]  nExBundle;

    int vectors;
    int miscompares;

    assign exBundle  = {ValidEX, ALUCtrlEX, ALUSrcImmEX, SignExtEX, ShamtSelEX, ShiftSwapEX, IllegalEX};
    assign nExBundle = {nValidEX, nALUCtrlEX, nALUSrcImmEX, nSignExtEX, nShamtSelEX, nShiftSwapEX, nIllegalEX};

    alu_ctrl_stage #(.CNT_WIDTH(8)) dut (
        .CLK(CLK), .Reset(Reset), .InstrID(InstrID), .ValidID(ValidID),
        .Stall(Stall), .Flush(Flush),
        .ValidEX(ValidEX), .ALUCtrlEX(ALUCtrlEX), .ALUSrcImmEX(ALUSrcImmEX),
        .SignExtEX(SignExtEX), .ShamtSelEX(ShamtSelEX), .ShiftSwapEX(ShiftSwapEX),
        .ShamtEX(ShamtEX), .IllegalEX(IllegalEX), .IllegalCount(IllegalCount)
    );

    alu_ctrl_stage #(.CNT_WIDTH(2)) dutNarrow (
        .CLK(CLK), .Reset(Reset), .InstrID(InstrID), .ValidID(ValidID),
        .Stall(Stall), .Flush(Flush),
        .ValidEX(nValidEX), .ALUCtrlEX(nALUCtrlEX), .ALUSrcImmEX(nALUSrcImmEX),
        .SignExtEX(nSignExtEX), .ShamtSelEX(nShamtSelEX), .ShiftSwapEX(nShiftSwapEX),
        .ShamtEX(nShamtEX), .IllegalEX(nIllegalEX), .IllegalCount(nIllegalCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drive one cycle of inputs, clock it in, and settle just after the edge.
    task automatic applyStimulus(input logic [31:0] instr, input logic valid,
                                 input logic stall, input logic flush, input logic rst);
        InstrID = instr;
        ValidID = valid;
        Stall   = stall;
        Flush   = flush;
        Reset   = rst;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        applyStimulus(32'h00221820, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(32'h00221820, 1'b1, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (exBundle !== 10'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_bundle got %b want %b", exBundle, 10'b0);
        end
        vectors++;
        if (ShamtEX !== 5'd0 || IllegalCount !== 8'd0 || nIllegalCount !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_state got shamt=%0d cnt=%0d ncnt=%0d want 0/0/0",
                     ShamtEX, IllegalCount, nIllegalCount);
        end
    endtask

    task automatic test_rtype();
        applyStimulus(32'h00221820, 1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (exBundle !== {1'b1, 4'b0010, 5'b00000}) begin
            miscompares++;
            $display("[TB] FAIL add got %b want %b", exBundle, {1'b1, 4'b0010, 5'b00000});
        end
        applyStimulus(32'h00031100, 1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (exBundle !== {1'b1, 4'b0011, 5'b00110} || ShamtEX !== 5'd4) begin
            miscompares++;
            $display("[TB] FAIL sll got %b shamt=%0d want %b shamt=4",
                     exBundle, ShamtEX, {1'b1, 4'b0011, 5'b00110});
        end
        applyStimulus(32'h00431007, 1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (exBundle !== {1'b1, 4'b1101, 5'b00010}) begin
            miscompares++;
            $display("[TB] FAIL srav got %b want %b", exBundle, {1'b1, 4'b1101, 5'b00010});
        end
        applyStimulus(32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (exBundle !== {1'b1, 4'b0011, 5'b00110} || ShamtEX !== 5'd0) begin
            miscompares++;
            $display("[TB] FAIL nop got %b shamt=%0d want %b shamt=0",
                     exBundle, ShamtEX, {1'b1, 4'b0011, 5'b00110});
        end
        applyStimulus(32'h00221822, 1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (exBundle !== {1'b1, 4'b0110, 5'b00000}) begin
            miscompares++;
            $display("[TB] FAIL sub got %b want %b", exBundle, {1'b1, 4'b0110, 5'b00000});
        end
    endtask

    task automatic test_immediates();
        applyStimulus(32'h3C011234, 1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (exBundle !== {1'b1, 4'b1110, 5'b10000}) begin
            miscompares++;
            $display("[TB] FAIL lui got %b want %b", exBundle, {1'b1, 4'b1110, 5'b10000});
        end
        applyStimulus(32'h3021FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (exBundle !== {1'b1, 4'b0000, 5'b10000}) begin
            miscompares++;
            $display("[TB] FAIL andi got %b want %b", exBundle, {1'b1, 4'b0000, 5'b10000});
        end
        applyStimulus(32'h2821FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (exBundle !== {1'b1, 4'b0111, 5'b11000}) begin
            miscompares++;
            $display("[TB] FAIL slti got %b want %b", exBundle, {1'b1, 4'b0111, 5'b11000});
        end
        applyStimulus(32'h10220003, 1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (exBundle !== {1'b1, 4'b0110, 5'b01000}) begin
            miscompares++;
            $display("[TB] FAIL beq got %b want %b", exBundle, {1'b1, 4'b0110, 5'b01000});
        end
        applyStimulus(32'h8C220004, 1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (exBundle !== {1'b1, 4'b0010, 5'b11000}) begin
            miscompares++;
            $display("[TB] FAIL lw got %b want %b", exBundle, {1'b1, 4'b0010, 5'b11000});
        end
    endtask

    task automatic test_stall_flush();
        logic [31:0] stallWords [3];
        stallWords[0] = 32'h3C011234;
        stallWords[1] = 32'h00031100;
        stallWords[2] = 32'h7C000000;
        applyStimulus(32'h00221821, 1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (exBundle !== {1'b1, 4'b1000, 5'b00000}) begin
            miscompares++;
            $display("[TB] FAIL addu got %b want %b", exBundle, {1'b1, 4'b1000, 5'b00000});
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(stallWords[i], 1'b1, 1'b1, 1'b0, 1'b0);
            vectors++;
            if (exBundle !== {1'b1, 4'b1000, 5'b00000} || IllegalCount !== 8'd0) begin
                miscompares++;
                $display("[TB] FAIL stall_hold%0d got %b cnt=%0d want %b cnt=0",
                         i, exBundle, IllegalCount, {1'b1, 4'b1000, 5'b00000});
            end
        end
        applyStimulus(32'h00031100, 1'b1, 1'b1, 1'b1, 1'b0);
        vectors++;
        if (exBundle !== 10'b0 || ShamtEX !== 5'd0) begin
            miscompares++;
            $display("[TB] FAIL stall_flush got %b shamt=%0d want 0 shamt=0", exBundle, ShamtEX);
        end
        applyStimulus(32'h00031100, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h7C000000, 1'b1, 1'b0, 1'b1, 1'b0);
        vectors++;
        if (exBundle !== 10'b0 || ShamtEX !== 5'd0 || IllegalCount !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL flush_only got %b shamt=%0d cnt=%0d want 0/0/0",
                     exBundle, ShamtEX, IllegalCount);
        end
    endtask

    task automatic test_illegal();
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(32'h7C000000, 1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (exBundle !== {1'b1, 4'b0010, 5'b00001} || IllegalCount !== 8'd1) begin
            miscompares++;
            $display("[TB] FAIL illegal_valid got %b cnt=%0d want %b cnt=1",
                     exBundle, IllegalCount, {1'b1, 4'b0010, 5'b00001});
        end
        applyStimulus(32'h7C000000, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (exBundle !== {1'b0, 4'b0010, 5'b00000} || IllegalCount !== 8'd1) begin
            miscompares++;
            $display("[TB] FAIL illegal_invalid got %b cnt=%0d want %b cnt=1",
                     exBundle, IllegalCount, {1'b0, 4'b0010, 5'b00000});
        end
        applyStimulus(32'h7C000000, 1'b1, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (exBundle !== {1'b0, 4'b0010, 5'b00000} || IllegalCount !== 8'd1) begin
            miscompares++;
            $display("[TB] FAIL illegal_stalled got %b cnt=%0d want %b cnt=1",
                     exBundle, IllegalCount, {1'b0, 4'b0010, 5'b00000});
        end
        applyStimulus(32'h00000001, 1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (exBundle !== {1'b1, 4'b0010, 5'b00001} || IllegalCount !== 8'd2) begin
            miscompares++;
            $display("[TB] FAIL illegal_funct got %b cnt=%0d want %b cnt=2",
                     exBundle, IllegalCount, {1'b1, 4'b0010, 5'b00001});
        end
    endtask

    task automatic test_saturation();
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(32'h7C000000, 1'b1, 1'b0, 1'b0, 1'b0);
            vectors++;
            if (nIllegalCount !== 2'((i > 3) ? 3 : i) || IllegalCount !== 8'(i)) begin
                miscompares++;
                $display("[TB] FAIL saturate%0d got ncnt=%0d cnt=%0d want ncnt=%0d cnt=%0d",
                         i, nIllegalCount, IllegalCount, (i > 3) ? 3 : i, i);
            end
        end
        vectors++;
        if (nExBundle !== {1'b1, 4'b0010, 5'b00001}) begin
            miscompares++;
            $display("[TB] FAIL narrow_bundle got %b want %b", nExBundle, {1'b1, 4'b0010, 5'b00001});
        end
        applyStimulus(32'h7C000000, 1'b1, 1'b1, 1'b1, 1'b1);
        vectors++;
        if (exBundle !== 10'b0 || IllegalCount !== 8'd0 || nIllegalCount !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_over_stall_flush got %b cnt=%0d ncnt=%0d want 0/0/0",
                     exBundle, IllegalCount, nIllegalCount);
        end
    endtask

    // Consecutive loads must each appear exactly one cycle after their accepting edge.
    task automatic test_back_to_back();
        applyStimulus(32'h00221820, 1'b1, 1'b0, 1'b0, 1'b0);
        InstrID = 32'h3C011234;
        #2;
        vectors++;
        if (exBundle !== {1'b1, 4'b0010, 5'b00000}) begin
            miscompares++;
            $display("[TB] FAIL latency_hold got %b want %b", exBundle, {1'b1, 4'b0010, 5'b00000});
        end
        applyStimulus(32'h3C011234, 1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (exBundle !== {1'b1, 4'b1110, 5'b10000}) begin
            miscompares++;
            $display("[TB] FAIL b2b_lui got %b want %b", exBundle, {1'b1, 4'b1110, 5'b10000});
        end
        applyStimulus(32'h00221827, 1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (exBundle !== {1'b1, 4'b1100, 5'b00000}) begin
            miscompares++;
            $display("[TB] FAIL b2b_nor got %b want %b", exBundle, {1'b1, 4'b1100, 5'b00000});
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        Reset   = 1'b1;
        InstrID = 32'h0;
        ValidID = 1'b0;
        Stall   = 1'b0;
        Flush   = 1'b0;
        test_reset();
        test_rtype();
        test_immediates();
        test_stall_flush();
        test_illegal();
        test_saturation();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
